// File: rtl/bp_update_scheduler.sv
// ============================================================================
//  Module      : bp_update_scheduler
//  Description : In-flight conditional-branch tracker between the fetch-stage
//                gshare predictor and the execute-stage branch unit. Holds one
//                entry per outstanding prediction, retires entries in program
//                order as execute resolves them, schedules one pattern-table
//                counter update per cycle, and on a mispredict squashes all
//                younger entries and hands the repaired global history back
//                to the predictor.
//  Options     : `define BP_STATS_EN adds the stat_branches / stat_mispred
//                32-bit event counters as extra output ports.
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module bp_update_scheduler #(
  parameter int DEPTH = 4,   // in-flight entries, power of 2, >= 2
  parameter int IDX_W = 10,  // pattern-table index width
  parameter int GHR_W = 10,  // global history width
  parameter int TAG_W = 15   // branch pc tag width
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  // prediction push from fetch
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic [TAG_W-1:0] pred_tag,
  input  logic             pred_taken,
  input  logic [GHR_W-1:0] pred_ghr,
  // in-order resolution from execute
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  // pattern-table update
  output logic             upd_we,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_inc,
  // recovery
  output logic             mispredict,
  output logic             ghr_restore,
  output logic [GHR_W-1:0] ghr_value,
  output logic             res_err
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
`endif
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Entry storage; contents are qualified by count, so no reset is needed.
  logic [IDX_W-1:0] mem_idx_q   [DEPTH];
  logic [TAG_W-1:0] mem_tag_q   [DEPTH];
  logic             mem_taken_q [DEPTH];
  logic [GHR_W-1:0] mem_ghr_q   [DEPTH];

  // Registered outputs (one cycle after the resolve that produced them)
  logic             upd_we_q, upd_we_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_inc_q, upd_inc_d;
  logic             mispredict_q, mispredict_d;
  logic             ghr_restore_q, ghr_restore_d;
  logic [GHR_W-1:0] ghr_value_q, ghr_value_d;
  logic             res_err_q, res_err_d;

  // --------------------------------------------------------------------------
  // Head-of-queue view and event decode
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] head_idx;
  logic [TAG_W-1:0] head_tag;
  logic             head_taken;
  logic [GHR_W-1:0] head_ghr;
  logic             not_empty;
  logic             res_hit;
  logic             res_miss;
  logic             mispred_now;
  logic             push;
  logic             pop;
  logic             unused_head_ghr_msb;

  assign head_idx   = mem_idx_q[rd_ptr_q];
  assign head_tag   = mem_tag_q[rd_ptr_q];
  assign head_taken = mem_taken_q[rd_ptr_q];
  assign head_ghr   = mem_ghr_q[rd_ptr_q];

  // The oldest history bit falls off the end when the actual outcome is
  // shifted in, so it never reaches the restored value.
  assign unused_head_ghr_msb = head_ghr[GHR_W-1];

  assign not_empty = (count_q != '0);

  // A resolve only retires the head when its tag matches; anything else is
  // an ordering error reported to execute and leaves the queue untouched.
  assign res_hit     = res_valid & not_empty & (res_tag == head_tag);
  assign res_miss    = res_valid & ~res_hit;
  assign mispred_now = res_hit & (res_taken != head_taken);

  // No bypass: a full queue stays not-ready even if the head pops this cycle.
  assign pred_ready = (count_q != CNT_FULL) & (state_q != ST_RECOVER) & ~flush;

  // A push that coincides with a mispredict belongs to the wrong path and is
  // silently dropped along with the other younger entries.
  assign push = pred_valid & pred_ready & ~mispred_now;
  assign pop  = res_hit & ~flush;

  // --------------------------------------------------------------------------
  // Pointer / occupancy next-state: flush and mispredict both empty the queue
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush || mispred_now) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM next-state: IDLE (empty), ACTIVE (entries pending),
  // RECOVER (one cycle of blocked pushes after a mispredict)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mispred_now) begin
          state_d = ST_RECOVER;
        end else if (count_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered output next-state; flush suppresses new events but whatever
  // was already captured last cycle still goes out
  // --------------------------------------------------------------------------
  always_comb begin
    upd_we_d      = pop;
    upd_idx_d     = upd_idx_q;
    upd_inc_d     = upd_inc_q;
    mispredict_d  = mispred_now & ~flush;
    ghr_restore_d = mispred_now & ~flush;
    ghr_value_d   = ghr_value_q;
    res_err_d     = res_miss & ~flush;
    if (pop) begin
      upd_idx_d = head_idx;
      upd_inc_d = res_taken;
    end
    if (mispred_now && !flush) begin
      ghr_value_d = {head_ghr[GHR_W-2:0], res_taken};
    end
  end

  // State, pointer and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      upd_we_q      <= 1'b0;
      upd_idx_q     <= '0;
      upd_inc_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      ghr_restore_q <= 1'b0;
      ghr_value_q   <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      upd_we_q      <= upd_we_d;
      upd_idx_q     <= upd_idx_d;
      upd_inc_q     <= upd_inc_d;
      mispredict_q  <= mispredict_d;
      ghr_restore_q <= ghr_restore_d;
      ghr_value_q   <= ghr_value_d;
      res_err_q     <= res_err_d;
    end
  end

  // Entry write at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx_q[wr_ptr_q]   <= pred_idx;
      mem_tag_q[wr_ptr_q]   <= pred_tag;
      mem_taken_q[wr_ptr_q] <= pred_taken;
      mem_ghr_q[wr_ptr_q]   <= pred_ghr;
    end
  end

  assign upd_we      = upd_we_q;
  assign upd_idx     = upd_idx_q;
  assign upd_inc     = upd_inc_q;
  assign mispredict  = mispredict_q;
  assign ghr_restore = ghr_restore_q;
  assign ghr_value   = ghr_value_q;
  assign res_err     = res_err_q;

`ifdef BP_STATS_EN
  // --------------------------------------------------------------------------
  // Event counters: cleared only by reset, free-running wrap at 2^32
  // --------------------------------------------------------------------------
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Count retired branches and the subset that were mispredicted
  always_comb begin
    stat_branches_d = stat_branches_q + 32'(pop);
    stat_mispred_d  = stat_mispred_q + 32'(mispred_now & ~flush);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

`default_nettype wire
